// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
//   alu_op_t    - 3-bit opcode
//   alu_state_t - control FSM state
//   FLAG_*      - bit positions inside the {N,Z,C,V} flag vector
package alu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpNot = 3'd4,
    OpShr = 3'd5,
    OpShl = 3'd6,
    OpMul = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } alu_state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle of the sequential ALU.
//   start, op, a, b                       - request (master drives)
//   busy, done, result_lo, result_hi, flags - response (slave drives)
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, flags
  );

endinterface

// File: rtl/alu_mul_booth.sv
// alu_mul_booth: signed WIDTH x WIDTH -> 2*WIDTH radix-2 Booth multiplier.
//   clk_100MHz, rst - clock, synchronous active-high reset
//   load            - capture a (multiplicand) and b (multiplier), start iterating
//   a, b            - signed operands
//   product         - signed 2*WIDTH product, valid while mul_done is high
//   mul_done        - high once all WIDTH iterations have run; cleared by load
module alu_mul_booth #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               mul_done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  // {acc[WIDTH-1:0], q[WIDTH-1:0], q_minus1}
  logic [2*WIDTH:0] booth_q, booth_d;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;
  logic             done_q;

  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   sum;

  always_comb begin
    // One guard bit keeps acc - (-2^(WIDTH-1)) from overflowing.
    acc_ext   = {booth_q[2*WIDTH], booth_q[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    sum       = acc_ext;
    unique case (booth_q[1:0])
      2'b01:   sum = acc_ext + mcand_ext;
      2'b10:   sum = acc_ext - mcand_ext;
      default: sum = acc_ext;
    endcase
    // Arithmetic right shift: the guard bit becomes the new acc sign.
    booth_d = {sum, booth_q[WIDTH:1]};
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      mcand_q <= '0;
      booth_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      mcand_q <= a;
      booth_q <= {{WIDTH{1'b0}}, b, 1'b0};
      cnt_q   <= CntW'(WIDTH - 1);
      run_q   <= 1'b1;
      done_q  <= 1'b0;
    end else if (run_q) begin
      booth_q <= booth_d;
      if (cnt_q == '0) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign product  = booth_q[2*WIDTH:1];
  assign mul_done = done_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/done handshake and registered NZCV flags.
//   clk_100MHz - system clock, rising edge
//   rst        - synchronous active-high reset; aborts any operation in flight
//   bus        - alu_seq_if slave: start/op/a/b in; busy/done/result_lo/result_hi/flags out
// Single-cycle ops finish two cycles after an accepted start, MUL after WIDTH+2.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic      clk_100MHz,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;

  logic               accept;
  logic               mul_load;
  logic [2*WIDTH-1:0] product;
  logic               mul_done;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     add_full;
  logic               prod_fits;

  assign accept   = (state_q == StIdle) && bus.start;
  assign mul_load = accept && (bus.op == OpMul);

  alu_mul_booth #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .load       (mul_load),
    .a          (bus.a),
    .b          (bus.b),
    .product    (product),
    .mul_done   (mul_done)
  );

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = (bus.op == OpMul) ? StMul : StExec;
      StExec: state_d = StDone;
      StMul:  if (mul_done) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Single-cycle datapath on the latched operands.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    add_full = {1'b0, a_q} + {1'b0, b_q};
    unique case (op_q)
      OpAdd: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = a_q - b_q;
        alu_c   = a_q < b_q;
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpNot: alu_res = ~a_q;
      OpShr: begin
        alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OpShl: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
        alu_v   = a_q[WIDTH-1] ^ a_q[WIDTH-2];
      end
      default: alu_res = '0;
    endcase
  end

  // Product fits in WIDTH signed bits when its top WIDTH+1 bits are all equal.
  assign prod_fits = (product[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){product[2*WIDTH-1]}});

  // Result/flag registers load only in the cycle before done.
  always_comb begin
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    if (state_q == StExec) begin
      res_lo_d         = alu_res;
      res_hi_d         = '0;
      flags_d[FLAG_N]  = alu_res[WIDTH-1];
      flags_d[FLAG_Z]  = (alu_res == '0);
      flags_d[FLAG_C]  = alu_c;
      flags_d[FLAG_V]  = alu_v;
    end else if ((state_q == StMul) && mul_done) begin
      res_lo_d         = product[WIDTH-1:0];
      res_hi_d         = product[2*WIDTH-1:WIDTH];
      flags_d[FLAG_N]  = product[2*WIDTH-1];
      flags_d[FLAG_Z]  = (product == '0);
      flags_d[FLAG_C]  = 1'b0;
      flags_d[FLAG_V]  = ~prod_fits;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      if (accept) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  // Counted at posedge: reads the pre-update value of done.
  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, compare against the scoreboard.
  // glitch > 0 pulses start for one cycle that many cycles into the op.
  task automatic do_op(input string tag, input alu_op_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] elo,
                       input logic [W-1:0] ehi, input logic [3:0] efl, input int glitch);
    exp_t e;
    int   cyc;
    int   base;
    int   lat;
    @(negedge clk);
    chk({tag, " idle"}, bus.busy, 1'b0);
    e.lo = elo;
    e.hi = ehi;
    e.flags = efl;
    sb.push_back(e);
    base = done_cnt;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == glitch) begin
        bus.start = 1'b1;
        bus.op = OpAdd;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    lat = (op == OpMul) ? W + 2 : 2;
    chk({tag, " latency"}, cyc, lat);
    e = sb.pop_front();
    chk({tag, " lo"}, bus.result_lo, e.lo);
    chk({tag, " hi"}, bus.result_hi, e.hi);
    chk({tag, " flags"}, bus.flags, e.flags);
    chk({tag, " busy@done"}, bus.busy, 1'b1);
    repeat (3) @(negedge clk);
    chk({tag, " one done"}, done_cnt - base, 1);
    chk({tag, " hold lo"}, bus.result_lo, e.lo);
    chk({tag, " hold flags"}, bus.flags, e.flags);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = OpAdd;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst lo", bus.result_lo, 16'h0);
    chk("rst hi", bus.result_hi, 16'h0);
    chk("rst flags", bus.flags, 4'h0);
    rst = 1'b0;

    do_op("shr", OpShr, 16'd5050, 16'd0, 16'd2525, 16'h0, 4'b0000, 0);
    do_op("shl", OpShl, 16'd2525, 16'd0, 16'd5050, 16'h0, 4'b0000, 0);
    do_op("not", OpNot, 16'd5050, 16'd0, 16'hEC45, 16'h0, 4'b1000, 0);
    do_op("sub", OpSub, 16'hEC45, 16'd100, 16'hEBE1, 16'h0, 4'b1000, 0);
    // Stray start mid-MUL must be ignored.
    do_op("mul", OpMul, 16'hEBE1, 16'hEC46, 16'hEB86, 16'h018C, 4'b0001, 3);
    do_op("add ovf", OpAdd, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'b1001, 0);
    do_op("not min", OpNot, 16'h8000, 16'h0, 16'h7FFF, 16'h0, 4'b0000, 0);
    do_op("add carry", OpAdd, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 4'b0110, 0);
    do_op("sub borrow", OpSub, 16'h0001, 16'h0002, 16'hFFFF, 16'h0, 4'b1010, 0);
    do_op("and", OpAnd, 16'h0F0F, 16'h00FF, 16'h000F, 16'h0, 4'b0000, 0);
    do_op("or", OpOr, 16'hF000, 16'h000F, 16'hF00F, 16'h0, 4'b1000, 0);
    do_op("shr neg", OpShr, 16'h8001, 16'h0, 16'hC000, 16'h0, 4'b1010, 0);
    do_op("shl ovf", OpShl, 16'h4000, 16'h0, 16'h8000, 16'h0, 4'b1001, 0);
    do_op("mul min", OpMul, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 4'b0001, 0);
    do_op("mul zero", OpMul, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'b0100, 0);
    do_op("mul neg", OpMul, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 4'b1000, 0);

    // Reset in the middle of a MUL: no done, everything cleared.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OpMul;
    bus.a = 16'h1234;
    bus.b = 16'h0056;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = done_cnt;
    chk("abort busy", bus.busy, 1'b0);
    repeat (W + 4) @(negedge clk);
    chk("abort no done", done_cnt - base, 0);
    chk("abort lo", bus.result_lo, 16'h0);
    chk("abort hi", bus.result_hi, 16'h0);
    chk("abort flags", bus.flags, 4'h0);

    do_op("post rst", OpAdd, 16'd1000, 16'd234, 16'd1234, 16'h0, 4'b0000, 0);
    do_op("post rst mul", OpMul, 16'd300, 16'hFFFE, 16'hFDA8, 16'hFFFF, 4'b1000, 0);

    chk("scoreboard empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the Simple-CPU datapath. It runs single-cycle ops (add, sub, logic, arithmetic shifts) and a signed WIDTH×WIDTH→2·WIDTH radix-2 Booth multiply that takes WIDTH cycles. It uses a start/done handshake and registers NZCV flags. The control unit stalls on `busy`, and the flags drive the board's `alu_flags` LEDs and conditional jumps (JMPGEZ uses N).

## Interface
- `WIDTH`, default 16: operand width; legal values are 8 to 32, even.
- `clk_100MHz`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request; sampled only when `busy`=0.
- `op`  in  3: opcode from `alu_pkg`.
- `a`, `b`  in  WIDTH each: signed operands, latched on an accepted start.
- `busy`  out  1: high from an accepted start until `done`.
- `done`  out  1: one-cycle pulse when the results are valid.
- `result_lo`  out  WIDTH: the result, or the low half of the product.
- `result_hi`  out  WIDTH: the high half of the product; 0 for all non-MUL ops.
- `flags`  out  4: {N,Z,C,V}.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, NOT=4 (~a), SHR=5 (a>>>1), SHL=6 (a<<1), MUL=7.
- States:
  - IDLE → EXEC on start (non-MUL) → DONE → IDLE.
  - IDLE → MUL on start (MUL) → DONE → IDLE.
- Accepted start: in IDLE with `start`=1, the block latches `op`, `a`, `b` and raises `busy` the next cycle.
- `start` while busy is ignored; no queueing.
- Flags:
  - ADD: C = carry out; V = signed overflow, i.e. operands share a sign and the result sign differs.
  - SUB (a−b): C = borrow (a<b unsigned); V = signed overflow.
  - AND, OR, NOT: C=0, V=0.
  - SHR: C = a[0]; V=0.
  - SHL: C = a[WIDTH−1]; V = a[WIDTH−1]^a[WIDTH−2].
  - MUL: N = product[2W−1]; Z = full 2W product == 0; C=0; V=1 when the product does not fit in WIDTH signed bits.
  - Non-MUL: N = result_lo MSB; Z = result_lo==0.
- MUL algorithm:
  - Radix-2 Booth on a {acc, q, q₋₁} register of 2W+1 bits, with an arithmetic shift every cycle.
  - Counter runs WIDTH−1 down to 0.
  - Multiplicand = −2^(W−1) must be handled correctly; form the add/sub in W+1 bits.
- Results and flags hold their values until the next `done`.

## Timing
- Reset: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `flags`=0, state IDLE.
- Reset in mid-operation aborts the operation immediately; no `done` is generated.
- Non-MUL latency: start accepted at cycle t → `done`=1 at cycle t+2.
- MUL latency: start accepted at cycle t → `done`=1 at cycle t+WIDTH+2.
- Outputs update in the same cycle that `done` rises.
- `busy` falls in the cycle after `done`. A start in that cycle is accepted, so back-to-back throughput is one op per latency+1 cycles.
- `rst` and `start` in the same cycle: reset wins.

## Structure
- `alu_pkg` holds:
  - the opcode enum `alu_op_t`;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the state enum.
- One sub-module, `alu_mul_booth`:
  - parameter WIDTH;
  - ports `load`, `a`, `b`, `product[2W-1:0]`, `mul_done`;
  - it owns the counter and the Booth register.
- The top-level FSM, single-cycle ops and flag logic live in `alu_seq`.

## Test plan
- SHR 5050 → 2525, flags 0000. SHL 2525 → 5050, flags 0000.
- NOT 5050 → 0xEC45 (−5051), N=1. SUB −5051−100 → 0xEBE1 (−5151), N=1, C=0, V=0.
- MUL −5151×−5050:
  - `done` exactly WIDTH+2 cycles after start;
  - {hi,lo} = 0x018C_EB86; N=0, Z=0, V=1.
- ADD 32767+1 → 0x8000, N=1, V=1, C=0; then NOT −32768 → 0x7FFF, flags 0000.
- MUL corners:
  - −32768×−32768 → 0x4000_0000, V=1;
  - 0×−1 → 0, Z=1;
  - −1×1 → 0xFFFF_FFFF, N=1, V=0.
- Control corners:
  - `start` pulsed during a MUL is ignored; the result is unchanged and only one `done` is seen.
  - `rst` mid-MUL → no `done`, all outputs 0.
  - The next op after reset completes normally.
